posit32_encode: RTL and testbench
=================================

// Module: posit32_encode
// PURPOSE
// - Pipelined posit<32,es> encoder: packs decoded fields (sign, regime, exponent, fraction) into a posit32_t word.
// - Inverse of the posit32 decode path. Sits at the output of the posit arithmetic units, ahead of writeback.
// - Two-stage pipeline with valid/ready handshake on both sides; full throughput of one word per cycle.
// PARAMETERS
// - es  2  exponent field width in bits (0..4)
// PORTS
// - clk        in   1   clock
// - rst        in   1   synchronous, active-high reset
// - in_valid   in   1   input fields valid
// - in_ready   out  1   encoder can accept input this cycle
// - in_sign    in   1   sign_t; 1 = negative
// - in_regime  in   32  signed regime k
// - in_exp     in   32  signed exponent; only bits [es-1:0] are used, value must be 0..2^es-1
// - in_frac    in   32  unsigned fraction, MSB-aligned, hidden bit excluded
// - in_zero    in   1   force the zero encoding
// - in_nar     in   1   force the NaR encoding; has priority over in_zero
// - out_valid  out  1   out_p valid
// - out_ready  in   1   downstream accepts out_p
// - out_p      out  32  posit32_t result
// BEHAVIOUR
// - Clock and reset: one clock. Reset is synchronous and active-high.
// - Reset values: out_valid=0, out_p=32'h0, both stage valid flags=0. in_ready=1 in the first cycle after reset.
//   An in-flight word at reset is dropped, not emitted.
// - Handshake: a transfer occurs when valid && ready on the same edge.
//   - Each stage loads when it is empty or its contents leave in the same cycle.
//   - in_ready = !s1_valid || s2_load.
//   - out_p and out_valid hold stable while out_valid && !out_ready.
//   - Simultaneous accept and emit is allowed.
// - Latency: 2 cycles from input handshake to out_valid when out_ready stays high.
// - Stage 1: builds the regime run and a 64-bit unrounded magnitude string.
//   - k>=0: (k+1) ones, then a zero.
//   - k<0: (-k) zeros, then a one.
//   - Then in_exp[es-1:0], then in_frac[31:0].
// - Saturation in stage 1, applied to the magnitude before negation:
//   - k >= 30 -> maxpos magnitude 31'h7FFFFFFF.
//   - k <= -31 -> minpos magnitude 31'h00000001.
//   - A nonzero value never encodes as zero or NaR.
// - Stage 2: takes the top 31 bits of the string as the magnitude.
//   - out_p = {1'b0, mag}; if sign=1, out_p = -{1'b0, mag} (two's complement of the whole word).
// - Specials override everything: in_nar -> 32'h80000000; in_zero -> 32'h00000000. in_sign is ignored for both.
// - Bits of the regime, exponent or fraction that fall past bit 0 are discarded (truncation), unless rounding is enabled.
// CONFIGURATION
// - POSIT_ENC_ROUND_EN defined: round to nearest, ties to even, on the magnitude.
//   - Guard bit is the first dropped bit; sticky is the OR of the remaining dropped bits.
//   - A carry may ripple into the exponent or regime fields.
//   - The rounded magnitude is clamped to 1..31'h7FFFFFFF.
//   - Rounding adds no latency; it is done in stage 2.
// - POSIT_ENC_ROUND_EN undefined: truncate the magnitude toward zero. Minpos is still enforced.
// STRUCTURE
// - posit_types package: posit32_t, sign_t.
//   - Add localparams POSIT32_NAR=32'h80000000, POSIT32_MAXPOS_MAG=31'h7FFFFFFF, POSIT32_MINPOS_MAG=31'h1.
//   - Add typedef posit_enc_fields_t (sign, regime, exp, frac, zero, nar).
// - One sub-module, posit_regime_pack: combinational; signed k -> regime run bits plus run length; used by stage 1.
// - The pipeline registers and handshake logic live in posit32_encode.
// TESTING (es=2)
// - regime=0, exp=0, frac=0, sign=0 -> 32'h40000000. Same with sign=1 -> 32'hC0000000.
// - regime=1 -> 32'h60000000. regime=-1 -> 32'h20000000. exp=3 with regime=0 -> 32'h58000000.
// - regime=40 -> 32'h7FFFFFFF. regime=-40 -> 32'h00000001. regime=-40 with sign=1 -> 32'hFFFFFFFF.
// - regime=0, exp=0, frac=32'hFFFFFFFF -> 32'h48000000 with POSIT_ENC_ROUND_EN, 32'h47FFFFFF without it.
// - in_nar=1 with in_zero=1 -> 32'h80000000. in_zero=1 with sign=1 -> 32'h00000000.
// - Backpressure and reset:
//   - Stream 8 words with in_valid=1; hold out_ready=0 for 5 cycles.
//   - Expect in_ready=0 after the 2 stalled words, out_p stable, then all 8 words in order with no loss or duplication.
//   - Assert rst mid-stream: out_valid=0 the next cycle, and no stale word is emitted.

Source files
------------

// File: rtl/posit_types_pkg.sv
// Package: posit_types
// Shared types and constants for the posit32 datapath.
//   posit32_t          - a packed 32-bit posit word
//   sign_t             - sign of a decoded value (1 = negative)
//   posit_enc_fields_t - decoded fields handed to the encoder
// Constants cover the NaR pattern and the largest and smallest
// nonzero magnitudes (sign bit excluded).
package posit_types;

    typedef logic [31:0] posit32_t;

    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } sign_t;

    localparam posit32_t    POSIT32_NAR        = 32'h80000000;
    localparam logic [30:0] POSIT32_MAXPOS_MAG = 31'h7FFFFFFF;
    localparam logic [30:0] POSIT32_MINPOS_MAG = 31'h1;

    typedef struct packed {
        sign_t              sign;
        logic signed [31:0] regime;
        logic [31:0]        exp;
        logic [31:0]        frac;
        logic               zero;
        logic               nar;
    } posit_enc_fields_t;

endpackage

// File: rtl/posit_regime_pack.sv
// Module: posit_regime_pack
// Combinational regime builder. Turns the signed regime value k into
// its run of identical bits plus the terminating opposite bit, packed
// MSB-first in run_bits.
//   k        in   32  signed regime value
//   run_bits out  32  regime run + terminator, left-aligned, zero padded
//   run_len  out  6   number of valid bits in run_bits
//   sat_max  out  1   k is too large to encode (k >= 30)
//   sat_min  out  1   k is too small to encode (k <= -31)
// When a saturation flag is set, run_bits/run_len still hold a legal
// (clamped) run, but the caller is expected to override the result.
module posit_regime_pack (
    input  logic signed [31:0] k,
    output logic [31:0]        run_bits,
    output logic [5:0]         run_len,
    output logic               sat_max,
    output logic               sat_min
);

    logic [5:0] run_count;
    logic [5:0] neg_k_low;

    assign sat_max = (k >= 32'sd30);
    assign sat_min = (k <= -32'sd31);

    // Only the low 6 bits of -k are needed, since k is clamped to -30..-1
    // whenever this value is used.
    assign neg_k_low = 6'd0 - k[5:0];

    // k >= 0 gives k+1 ones then a zero; k < 0 gives -k zeros then a one.
    always_comb begin
        run_count = 6'd0;
        run_bits  = 32'h0;
        run_len   = 6'd0;
        if (!k[31]) begin
            run_count = sat_max ? 6'd29 : k[5:0];
            run_bits  = ~(32'hFFFFFFFF >> (run_count + 6'd1));
            run_len   = run_count + 6'd2;
        end else begin
            run_count = sat_min ? 6'd30 : neg_k_low;
            run_bits  = 32'h80000000 >> run_count;
            run_len   = run_count + 6'd1;
        end
    end

endmodule

// File: rtl/posit32_encode.sv
// Module: posit32_encode
// Two-stage pipelined posit<32,es> encoder with valid/ready on both sides.
// Stage 1 assembles the unrounded magnitude string (regime, exponent,
// fraction) and applies saturation; stage 2 trims it to 31 bits,
// applies the sign and the special encodings, and registers the word.
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake
//   in_sign              1 = negative
//   in_regime            signed regime k
//   in_exp               exponent, only bits [es-1:0] used
//   in_frac              fraction, MSB-aligned, hidden bit excluded
//   in_zero / in_nar     force zero / NaR (NaR wins)
//   out_valid / out_ready output handshake
//   out_p                encoded posit word
// Optional feature: define POSIT_ENC_ROUND_EN for round-to-nearest-even
// on the magnitude; otherwise the magnitude is truncated.
module posit32_encode
    import posit_types::*;
#(
    parameter int es = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic signed [31:0] in_regime,
    input  logic [31:0]        in_exp,
    input  logic [31:0]        in_frac,
    input  logic               in_zero,
    input  logic               in_nar,
    output logic               out_valid,
    input  logic               out_ready,
    output posit32_t           out_p
);

    localparam int WIDE = 64 + es;

    posit_enc_fields_t fields;
    logic [es+31:0]    body;
    logic [31:0]       run_bits;
    logic [5:0]        run_len;
    logic              sat_max;
    logic              sat_min;
    logic [WIDE-1:0]   wide_str;
    logic [63:0]       folded_str;
    logic [63:0]       s1_str_next;
    logic              unused_exp_bits;

    logic              s1_valid;
    sign_t             s1_sign;
    logic              s1_zero;
    logic              s1_nar;
    logic [63:0]       s1_str;

    logic              s1_load;
    logic              s2_load;
    logic [30:0]       mag_trunc;
    logic [30:0]       mag_rounded;
    logic [30:0]       mag;
    posit32_t          s2_word;

    assign fields = '{sign: sign_t'(in_sign), regime: in_regime, exp: in_exp,
                      frac: in_frac, zero: in_zero, nar: in_nar};

    assign unused_exp_bits = ^fields.exp[31:es];

    posit_regime_pack u_regime (
        .k        (fields.regime),
        .run_bits (run_bits),
        .run_len  (run_len),
        .sat_max  (sat_max),
        .sat_min  (sat_min)
    );

    generate
        if (es > 0) begin : g_with_exp
            assign body = {fields.exp[es-1:0], fields.frac};
        end else begin : g_no_exp
            assign body = fields.frac;
        end
    endgenerate

    // The 32 trailing zeros give the body room to slide right by the
    // whole regime length without losing any bit.
    assign wide_str = {run_bits, {(32 + es){1'b0}}} | ({body, 32'h0} >> run_len);

    // Bits below the 64-bit window are folded into bit 0 so they still
    // count toward sticky when rounding.
    generate
        if (es > 0) begin : g_fold
            assign folded_str = {wide_str[WIDE-1 -: 63], wide_str[es] | (|wide_str[es-1:0])};
        end else begin : g_nofold
            assign folded_str = wide_str;
        end
    endgenerate

    assign s1_str_next = sat_max ? {POSIT32_MAXPOS_MAG, 33'h0} :
                         sat_min ? {POSIT32_MINPOS_MAG, 33'h0} : folded_str;

    // A stage loads when it is empty or its current word leaves this cycle.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    assign mag_trunc = s1_str[63:33];

`ifdef POSIT_ENC_ROUND_EN
    logic        guard_bit;
    logic        sticky_bit;
    logic [31:0] rounded_sum;

    assign guard_bit   = s1_str[32];
    assign sticky_bit  = |s1_str[31:0];
    assign rounded_sum = {1'b0, mag_trunc} + {31'h0, guard_bit & (sticky_bit | mag_trunc[0])};
    // A carry out of the 31-bit field would land on the sign bit, so clamp.
    assign mag_rounded = rounded_sum[31] ? POSIT32_MAXPOS_MAG : rounded_sum[30:0];
`else
    logic unused_round_bits;

    assign unused_round_bits = ^s1_str[32:0];
    assign mag_rounded       = mag_trunc;
`endif

    assign mag = (mag_rounded == 31'h0) ? POSIT32_MINPOS_MAG : mag_rounded;

    // Specials win over the sign; negative values are the two's complement
    // of the whole word.
    always_comb begin
        s2_word = {1'b0, mag};
        if (s1_nar) begin
            s2_word = POSIT32_NAR;
        end else if (s1_zero) begin
            s2_word = 32'h0;
        end else if (s1_sign == SIGN_NEG) begin
            s2_word = 32'h0 - {1'b0, mag};
        end
    end

    // Both pipeline stages; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= 32'h0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_sign  <= fields.sign;
                s1_zero  <= fields.zero;
                s1_nar   <= fields.nar;
                s1_str   <= s1_str_next;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid <= 1'b1;
                out_p     <= s2_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_posit32_encode.sv
// Testbench: tb_posit32_encode
// Directed checks of the posit32 encoder with es=2: reset state, single
// words covering regime/exponent/fraction placement, saturation, specials,
// the rounding/truncation case, a backpressure stream and a mid-stream reset.
module tb_posit32_encode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [31:0] in_regime;
    logic [31:0] in_exp;
    logic [31:0] in_frac;
    logic        in_zero;
    logic        in_nar;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;

    int n_checks;
    int n_fail;

`ifdef POSIT_ENC_ROUND_EN
    localparam logic [31:0] FRAC_ALL_ONES_EXP = 32'h48000000;
`else
    localparam logic [31:0] FRAC_ALL_ONES_EXP = 32'h47FFFFFF;
`endif

    posit32_encode #(.es(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_regime (in_regime),
        .in_exp    (in_exp),
        .in_frac   (in_frac),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveFields(input logic s, input logic [31:0] r, input logic [31:0] e,
                               input logic [31:0] f, input logic z, input logic n);
        in_sign   = s;
        in_regime = r;
        in_exp    = e;
        in_frac   = f;
        in_zero   = z;
        in_nar    = n;
    endtask

    // Present one word and hold it until the encoder takes it.
    task automatic applyStimulus(input logic s, input logic [31:0] r, input logic [31:0] e,
                                 input logic [31:0] f, input logic z, input logic n);
        int waited;
        @(negedge clk);
        driveFields(s, r, e, f, z, n);
        in_valid = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutput(input string tag, input logic [31:0] expected);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1'b1);
        checkOutput(tag, out_p, expected);
    endtask

    logic        bp_sign [8];
    logic [31:0] bp_regime [8];
    logic [31:0] bp_exp [8];
    logic [31:0] bp_frac [8];
    logic [31:0] bp_expect [8];
    logic [31:0] recv [$];
    int          sent;
    int          stale;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        driveFields(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        bp_sign[0] = 1'b0; bp_regime[0] = 32'd0;   bp_exp[0] = 32'd0; bp_frac[0] = 32'h0;        bp_expect[0] = 32'h40000000;
        bp_sign[1] = 1'b1; bp_regime[1] = 32'd0;   bp_exp[1] = 32'd0; bp_frac[1] = 32'h0;        bp_expect[1] = 32'hC0000000;
        bp_sign[2] = 1'b0; bp_regime[2] = 32'd1;   bp_exp[2] = 32'd0; bp_frac[2] = 32'h0;        bp_expect[2] = 32'h60000000;
        bp_sign[3] = 1'b0; bp_regime[3] = -32'd1;  bp_exp[3] = 32'd0; bp_frac[3] = 32'h0;        bp_expect[3] = 32'h20000000;
        bp_sign[4] = 1'b0; bp_regime[4] = 32'd0;   bp_exp[4] = 32'd3; bp_frac[4] = 32'h0;        bp_expect[4] = 32'h58000000;
        bp_sign[5] = 1'b0; bp_regime[5] = 32'd40;  bp_exp[5] = 32'd0; bp_frac[5] = 32'h0;        bp_expect[5] = 32'h7FFFFFFF;
        bp_sign[6] = 1'b1; bp_regime[6] = -32'd40; bp_exp[6] = 32'd0; bp_frac[6] = 32'h0;        bp_expect[6] = 32'hFFFFFFFF;
        bp_sign[7] = 1'b0; bp_regime[7] = 32'd0;   bp_exp[7] = 32'd1; bp_frac[7] = 32'h80000000; bp_expect[7] = 32'h4C000000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_p", out_p, 32'h0);
        checkOutput("reset_in_ready", in_ready, 1'b1);

        // Single words, one at a time.
        applyStimulus(1'b0, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k0_pos", 32'h40000000);
        applyStimulus(1'b1, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k0_neg", 32'hC0000000);
        applyStimulus(1'b0, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k1", 32'h60000000);
        applyStimulus(1'b0, -32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("km1", 32'h20000000);
        applyStimulus(1'b0, 32'd0, 32'd3, 32'h0, 1'b0, 1'b0);
        waitOutput("k0_e3", 32'h58000000);
        applyStimulus(1'b0, 32'd0, 32'd1, 32'h80000000, 1'b0, 1'b0);
        waitOutput("k0_e1_frac", 32'h4C000000);
        applyStimulus(1'b0, 32'd29, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k29", 32'h7FFFFFFE);
        applyStimulus(1'b0, 32'd30, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k30_sat", 32'h7FFFFFFF);
        applyStimulus(1'b0, 32'd40, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("k40_sat", 32'h7FFFFFFF);
        applyStimulus(1'b0, -32'd30, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("km30", 32'h00000001);
        applyStimulus(1'b0, -32'd40, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("km40_minpos", 32'h00000001);
        applyStimulus(1'b1, -32'd40, 32'd0, 32'h0, 1'b0, 1'b0);
        waitOutput("km40_neg", 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        waitOutput("frac_ones", FRAC_ALL_ONES_EXP);
        applyStimulus(1'b1, 32'd5, 32'd2, 32'h12345678, 1'b1, 1'b1);
        waitOutput("nar_over_zero", 32'h80000000);
        applyStimulus(1'b1, 32'd5, 32'd2, 32'h12345678, 1'b1, 1'b0);
        waitOutput("zero_neg", 32'h00000000);

        // Stream 8 words while the output is stalled for the first 5 cycles.
        sent = 0;
        for (int cyc = 0; cyc < 60 && recv.size() < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (sent < 8) begin
                in_valid = 1'b1;
                driveFields(bp_sign[sent], bp_regime[sent], bp_exp[sent], bp_frac[sent], 1'b0, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2 || cyc == 4) begin
                checkOutput("bp_stall_in_ready", in_ready, 1'b0);
                checkOutput("bp_stall_out_p", out_p, bp_expect[0]);
                checkOutput("bp_stall_out_valid", out_valid, 1'b1);
            end
            if (cyc == 4) checkOutput("bp_accepted", sent, 32'd2);
            if (out_valid && out_ready) recv.push_back(out_p);
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_count", 32'(recv.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < recv.size()) checkOutput($sformatf("bp_word%0d", i), recv[i], bp_expect[i]);
        end

        // Fill both stages, then reset: nothing already inside may come out.
        out_ready = 1'b0;
        applyStimulus(1'b0, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, -32'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 1'b0);
        checkOutput("rst_mid_out_p", out_p, 32'h0);
        checkOutput("rst_mid_in_ready", in_ready, 1'b1);
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("rst_no_stale", stale, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd3, 32'h0, 1'b0, 1'b0);
        waitOutput("post_reset_word", 32'h58000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
